// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - four-channel LED blink interval monitor
// Measures toggle-to-toggle intervals per LED and flags out-of-tolerance and stuck channels.
module blink_monitor #(
  parameter int CNT_W = 24,
  parameter int TOL   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LED0,
  input  logic             LED1,
  input  logic             LED2,
  input  logic             LED3,
  input  logic [CNT_W-1:0] EXP_HALF,
  input  logic             CLR,
  input  logic [1:0]       SEL,
  output logic [CNT_W-1:0] PERIOD,
  output logic [3:0]       VALID,
  output logic [3:0]       ERR,
  output logic [3:0]       STUCK
);

  typedef enum logic {WAIT_EDGE, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);

  logic [3:0]       led_in;
  logic [3:0]       sync1_q, sync2_q, hist_q;
  logic [3:0]       tgl;
  state_t           state_q [4];
  state_t           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [CNT_W-1:0] intv_q  [4];
  logic [CNT_W-1:0] intv_d  [4];
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       err_q, err_d;
  logic [3:0]       stuck_q, stuck_d;
  logic [3:0]       meas;

  assign led_in = {LED3, LED2, LED1, LED0};
  assign tgl    = sync2_q ^ hist_q;

  // Extra bit keeps the subtraction from wrapping when the interval and EXP_HALF are far apart.
  function automatic logic [CNT_W:0] abs_dev(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] wa, wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

  always_comb begin
    valid_d  = valid_q;
    err_d    = CLR ? 4'b0000 : err_q;
    stuck_d  = 4'b0000;
    meas     = 4'b0000;
    period_d = intv_q[SEL];
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      intv_d[i]  = intv_q[i];
      case (state_q[i])
        WAIT_EDGE: begin
          cnt_d[i] = '0;
          if (tgl[i]) begin
            state_d[i] = COUNT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        COUNT: begin
          if (tgl[i]) begin
            meas[i]   = 1'b1;
            intv_d[i] = cnt_q[i];
            cnt_d[i]  = CNT_ONE;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = WAIT_EDGE;
          cnt_d[i]   = '0;
        end
      endcase
      if (meas[i]) begin
        valid_d[i] = 1'b1;
        if (abs_dev(cnt_q[i], EXP_HALF) > TOL_W) err_d[i] = 1'b1;
      end
      stuck_d[i] = (state_d[i] == COUNT) && (cnt_d[i] == CNT_MAX) && !tgl[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      period_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      stuck_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= WAIT_EDGE;
        cnt_q[i]   <= '0;
        intv_q[i]  <= '0;
      end
    end else begin
      sync1_q  <= led_in;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        intv_q[i]  <= intv_d[i];
      end
    end
  end

  assign PERIOD = period_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;
  assign STUCK  = stuck_q;

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - directed self-checking bench for blink_monitor
// Table of single-interval vectors plus hand-written multi-cycle sequences.
module tb_blink_monitor;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [3:0]       led;
  logic [CNT_W-1:0] exp_half;
  logic             clr;
  logic [1:0]       sel;
  logic [CNT_W-1:0] period;
  logic [3:0]       valid, err, stuck;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int ch;
    int n;
    int period;
    bit err;
  } vec_t;

  vec_t vecs [10];

  blink_monitor #(.CNT_W(CNT_W), .TOL(2)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .LED0     (led[0]),
    .LED1     (led[1]),
    .LED2     (led[2]),
    .LED3     (led[3]),
    .EXP_HALF (exp_half),
    .CLR      (clr),
    .SEL      (sel),
    .PERIOD   (period),
    .VALID    (valid),
    .ERR      (err),
    .STUCK    (stuck)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    led   = 4'b0000;
    clr   = 1'b0;
    RST_N = 1'b0;
    tick(2);
    RST_N = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " period"}, 32'(period), 0);
    check({tag, " valid"},  32'(valid),  0);
    check({tag, " err"},    32'(err),    0);
    check({tag, " stuck"},  32'(stuck),  0);
  endtask

  initial begin
    exp_half = 8'd10;
    sel      = 2'd0;
    clr      = 1'b0;
    led      = 4'b0000;

    vecs[0] = '{0,  10,  10, 1'b0};
    vecs[1] = '{1,  12,  12, 1'b0};
    vecs[2] = '{2,  13,  13, 1'b1};
    vecs[3] = '{3,   8,   8, 1'b0};
    vecs[4] = '{0,   7,   7, 1'b1};
    vecs[5] = '{1,   1,   1, 1'b1};
    vecs[6] = '{2, 255, 255, 1'b1};
    vecs[7] = '{3, 300, 255, 1'b1};
    vecs[8] = '{0,  11,  11, 1'b0};
    vecs[9] = '{1,   9,   9, 1'b0};

    do_reset();
    check_zero("reset");

    // Single interval per vector: arm toggle, wait n, measuring toggle.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      sel = 2'(vecs[v].ch);
      tick(2);
      led[vecs[v].ch] = ~led[vecs[v].ch];
      tick(vecs[v].n);
      led[vecs[v].ch] = ~led[vecs[v].ch];
      tick(4);
      check($sformatf("vec%0d period", v), 32'(period), 32'(vecs[v].period));
      check($sformatf("vec%0d err", v),    32'(err),    32'(vecs[v].err) << vecs[v].ch);
      check($sformatf("vec%0d valid", v),  32'(valid),  32'(1) << vecs[v].ch);
    end

    // LED0 every 10 cycles, 5 toggles.
    do_reset();
    sel = 2'd0;
    tick(2);
    for (int t = 0; t < 5; t++) begin
      led[0] = ~led[0];
      tick(10);
    end
    check("led0 valid", 32'(valid), 32'h1);
    check("led0 period", 32'(period), 10);
    check("led0 err", 32'(err), 0);

    // LED1 intervals 10, 13, 12 with sticky ERR, then CLR.
    do_reset();
    sel = 2'd1;
    tick(2);
    led[1] = ~led[1]; tick(10);
    led[1] = ~led[1]; tick(4);
    check("led1 err after 10", 32'(err), 0);
    tick(9);
    led[1] = ~led[1]; tick(4);
    check("led1 err after 13", 32'(err), 32'h2);
    tick(8);
    led[1] = ~led[1]; tick(4);
    check("led1 err held", 32'(err), 32'h2);
    check("led1 period", 32'(period), 12);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("led1 clr", 32'(err), 0);

    // LED2 stuck: saturation edge then recovery.
    do_reset();
    sel = 2'd2;
    tick(2);
    led[2] = ~led[2];
    tick(256);
    check("led2 not yet stuck", 32'(stuck), 0);
    tick(1);
    check("led2 stuck", 32'(stuck), 32'h4);
    tick(40);
    check("led2 still stuck", 32'(stuck), 32'h4);
    led[2] = ~led[2];
    tick(4);
    check("led2 stuck cleared", 32'(stuck), 0);
    check("led2 period", 32'(period), 255);
    check("led2 err", 32'(err), 32'h4);

    // All four together every 8 cycles; deviation equals TOL.
    do_reset();
    tick(2);
    for (int t = 0; t < 5; t++) begin
      led = ~led;
      tick(8);
    end
    check("all valid", 32'(valid), 32'hF);
    check("all err", 32'(err), 0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick(1);
      check($sformatf("all period sel%0d", s), 32'(period), 8);
    end

    // Reset in the middle of LED3 counting.
    do_reset();
    sel = 2'd3;
    tick(2);
    led[3] = 1'b1; tick(10);
    led[3] = 1'b0; tick(6);
    check("led3 pre valid", 32'(valid), 32'h8);
    RST_N = 1'b0; tick(1); RST_N = 1'b1;
    check_zero("midreset");
    tick(2);
    led[3] = 1'b1; tick(4);
    check("led3 arm only", 32'(valid), 0);
    tick(7);
    led[3] = 1'b0; tick(4);
    check("led3 post valid", 32'(valid), 32'h8);
    check("led3 post period", 32'(period), 11);

    // CLR coinciding with an out-of-tolerance measurement on LED0.
    do_reset();
    sel = 2'd0;
    tick(2);
    led[1] = ~led[1]; tick(5);
    led[1] = ~led[1]; tick(4);
    check("collide pre err", 32'(err), 32'h2);
    led[0] = ~led[0]; tick(13);
    led[0] = ~led[0]; tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("collide err", 32'(err), 32'h1);
    tick(2);
    check("collide period", 32'(period), 13);

    // LED high at reset release arms only.
    led   = 4'b0001;
    RST_N = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(6);
    check("high release valid", 32'(valid), 0);
    led[0] = 1'b0; tick(10);
    led[0] = 1'b1; tick(4);
    check("high release period", 32'(period), 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blink_monitor.md
BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 Parameter CNT_W, default 24: width of the per-channel interval counter and of the period values.
REQ-002 Parameter TOL, default 16: allowed absolute deviation, in clock cycles, of a measured interval from EXP_HALF.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 LED0, LED1, LED2, LED3  input  1 each  asynchronous LED lines under observation (channels 0..3).
REQ-006 EXP_HALF  input  CNT_W  expected cycles between consecutive toggles (half period); quasi-static.
REQ-007 CLR  input  1  synchronous clear of the sticky ERR bits.
REQ-008 SEL  input  2  channel whose last measured interval drives PERIOD.
REQ-009 PERIOD  output  CNT_W  last measured interval of channel SEL, registered.
REQ-010 VALID  output  4  bit i = channel i has completed at least one interval measurement.
REQ-011 ERR  output  4  bit i = sticky out-of-tolerance flag for channel i.
REQ-012 STUCK  output  4  bit i = channel i counter saturated with no toggle.

Function
REQ-013 Each LED input SHALL pass through a 2-flop synchronizer and then a history flop; a toggle is detected when the synchronizer output differs from the history flop.
REQ-014 A toggle on an LED first sampled at rising edge k SHALL update that channel's VALID, ERR, STUCK and stored interval at rising edge k+2.
REQ-015 Each channel SHALL run an independent FSM with states WAIT_EDGE and COUNT.
REQ-016 WAIT_EDGE: counter held at 0; on a detected toggle -> COUNT, with no measurement.
REQ-017 COUNT: counter increments by 1 per cycle; on a detected toggle, the stored interval = cycles since the previous toggle, and the counter restarts, staying in COUNT.
REQ-018 Toggles detected N cycles apart SHALL yield a stored interval of exactly N, for 1 <= N <= 2^CNT_W-1.
REQ-019 The counter SHALL saturate at 2^CNT_W-1 without wrapping; while saturated, STUCK[i]=1.
REQ-020 A toggle after saturation SHALL store 2^CNT_W-1, clear STUCK[i] and restart the count.
REQ-021 On each measurement, VALID[i] SHALL be set and remain set until reset.
REQ-022 ERR[i] SHALL be set on a measurement where |interval - EXP_HALF| > TOL.
REQ-023 The difference in REQ-022 SHALL be computed in CNT_W+1 bits without overflow; a deviation exactly equal to TOL is not an error.
REQ-024 CLR=1 SHALL clear all ERR bits at the next edge; an error set in the same cycle SHALL win for that channel.
REQ-025 PERIOD SHALL be registered from the stored interval of channel SEL, lagging a SEL change or a measurement by one cycle.
REQ-026 Simultaneous toggles on several channels SHALL be measured independently, with no interaction.

Reset
REQ-027 With RST_N=0 at a rising edge, the following SHALL all be 0 on the next cycle: synchronizer and history flops, counters, stored intervals, PERIOD, VALID, ERR and STUCK; all FSMs SHALL be in WAIT_EDGE.
REQ-028 Reset SHALL override CLR and any in-progress measurement.
REQ-029 After reset, the first toggle on a channel SHALL only arm it, including an LED that is high at reset release and so appears as a rising toggle.

Verification (CNT_W=8, TOL=2, EXP_HALF=10)
REQ-030 LED0 toggles every 10 cycles for 5 toggles -> VALID=0001, PERIOD(SEL=0)=10, ERR=0000.
REQ-031 LED1 toggles at intervals 10, 13, 12 -> ERR[1] set after the 13 measurement and held; PERIOD(SEL=1)=12; CLR pulse clears ERR to 0000.
REQ-032 LED2 toggles once, then stays constant for 300 cycles -> STUCK[2]=1 from 255 cycles after the toggle; the next toggle stores 255, sets ERR[2] and clears STUCK[2].
REQ-033 All four LEDs toggle together every 8 cycles -> all VALID=1; ERR=0000 (|8-10|=2=TOL); PERIOD=8 for every SEL.
REQ-034 RST_N=0 for 1 cycle in the middle of LED3 counting -> all outputs 0; the next toggle arms only; the second toggle yields a correct PERIOD.
REQ-035 CLR asserted in the same cycle as an out-of-tolerance measurement on LED0 -> ERR[0]=1 afterwards.
